// File: rtl/gain_applier.sv
// gain_applier: scales signed samples by a signed Q-format gain using a shift-add multiplier,
// rounding toward zero and saturating to the sample range.
module gain_applier #(
   parameter int DATA_SIZE = 14,
   parameter int FRAC_SIZE = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic [DATA_SIZE-1:0] i_quotient,
   input  logic                 i_quotient_valid,
   input  logic [DATA_SIZE-1:0] i_sample,
   input  logic                 i_start,
   output logic [DATA_SIZE-1:0] o_sample,
   output logic                 o_valid,
   output logic                 o_saturated,
   output logic                 o_busy,
   output logic                 o_dropped
);
   localparam int AW = 2 * DATA_SIZE;
   localparam int CW = $clog2(DATA_SIZE);
   localparam logic [AW-1:0] NEG_LIM = AW'(1) << (DATA_SIZE - 1);
   localparam logic [AW-1:0] POS_LIM = NEG_LIM - AW'(1);
   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
   state_t r_state, w_next;
   logic [DATA_SIZE-1:0] r_gain, r_smag, w_gain, w_smag, w_gmag, w_clip, w_res;
   logic [AW-1:0] r_acc, r_gsh, w_mag, w_lim;
   logic [CW-1:0] r_cnt;
   logic r_neg, w_accept, w_sat;
   assign w_accept = i_start && (r_state != MULT);
   assign w_gain = i_quotient_valid ? i_quotient : r_gain;
   assign w_smag = i_sample[DATA_SIZE-1] ? -i_sample : i_sample;
   assign w_gmag = w_gain[DATA_SIZE-1] ? -w_gain : w_gain;
   // Negative results may reach one count further than positive ones.
   assign w_mag = r_acc >> FRAC_SIZE;
   assign w_lim = r_neg ? NEG_LIM : POS_LIM;
   assign w_sat = w_mag > w_lim;
   assign w_clip = w_sat ? w_lim[DATA_SIZE-1:0] : w_mag[DATA_SIZE-1:0];
   assign w_res = r_neg ? -w_clip : w_clip;
   assign o_busy = (r_state == MULT);
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      w_next = (r_state == MULT) ? ((r_cnt == CW'(DATA_SIZE - 1)) ? DONE : MULT)
                                 : (i_start ? MULT : IDLE);
   end
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_gain      <= DATA_SIZE'(1 << FRAC_SIZE);
         r_smag      <= '0;
         r_gsh       <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         o_sample    <= '0;
         o_valid     <= 1'b0;
         o_saturated <= 1'b0;
         o_dropped   <= 1'b0;
      end else begin
         if (i_quotient_valid) r_gain <= i_quotient;
         o_dropped <= i_start && (r_state == MULT);
         o_valid   <= (r_state == DONE);
         if (r_state == DONE) begin
            o_sample    <= w_res;
            o_saturated <= w_sat;
         end
         if (w_accept) begin
            r_smag <= w_smag;
            r_gsh  <= {{DATA_SIZE{1'b0}}, w_gmag};
            r_acc  <= '0;
            r_cnt  <= '0;
            r_neg  <= i_sample[DATA_SIZE-1] ^ w_gain[DATA_SIZE-1];
         end else if (r_state == MULT) begin
            if (r_smag[0]) r_acc <= r_acc + r_gsh;
            r_gsh  <= r_gsh << 1;
            r_smag <= r_smag >> 1;
            r_cnt  <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_gain_applier.sv
// tb_gain_applier: table-driven directed cases, hand-written timing sequences and
// randomized streams checked against an arithmetic reference model.
module tb_gain_applier;
   logic clk = 1'b0, rst_n = 1'b0;
   logic signed [13:0] i_quotient = '0, i_sample = '0;
   logic i_quotient_valid = 1'b0, i_start = 1'b0;
   logic signed [13:0] o_sample;
   logic o_valid, o_saturated, o_busy, o_dropped;
   int n_cmp = 0, n_err = 0;
   logic signed [13:0] model_gain = 14'sd256;
   always #5 clk = ~clk;
   gain_applier dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_quotient(i_quotient),
      .i_quotient_valid(i_quotient_valid), .i_sample(i_sample), .i_start(i_start),
      .o_sample(o_sample), .o_valid(o_valid), .o_saturated(o_saturated),
      .o_busy(o_busy), .o_dropped(o_dropped)
   );
   typedef struct {
      bit load;
      logic signed [13:0] g, s, e;
      bit sat;
   } vec_t;
   vec_t tbl[8];
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // Product truncated toward zero (SV integer division), then clipped to 14-bit range.
   function automatic void ref_scale(input logic signed [13:0] g, input logic signed [13:0] s,
                                     output logic signed [13:0] r, output logic sat);
      int q;
      q = (int'(g) * int'(s)) / 256;
      sat = (q > 8191) || (q < -8192);
      r = (q > 8191) ? 14'sd8191 : (q < -8192) ? -14'sd8192 : 14'(q);
   endfunction
   task automatic set_gain(input logic signed [13:0] g);
      i_quotient = g;
      i_quotient_valid = 1'b1;
      model_gain = g;
      @(negedge clk);
      i_quotient_valid = 1'b0;
   endtask
   // ev_kind: 0 none, 1 quotient strobe with ev_val, 2 extra start with sample ev_val; driven ev_at edges after accept.
   task automatic do_op(input logic signed [13:0] s, input int ev_at, input int ev_kind,
                        input logic signed [13:0] ev_val, output logic signed [13:0] got,
                        output logic got_sat, output int lat, output bit busy_mid, output bit drop_seen);
      i_sample = s;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_quotient_valid = 1'b0;
      lat = 0;
      busy_mid = 0;
      drop_seen = 0;
      while (!o_valid && lat < 40) begin
         i_start = (ev_kind == 2 && lat == ev_at);
         i_quotient_valid = (ev_kind == 1 && lat == ev_at);
         if (ev_kind == 1 && lat == ev_at) i_quotient = ev_val;
         if (ev_kind == 2 && lat == ev_at) i_sample = ev_val;
         @(negedge clk);
         lat++;
         if (lat == 5) busy_mid = o_busy;
         if (o_dropped) drop_seen = 1;
      end
      i_start = 1'b0;
      i_quotient_valid = 1'b0;
      got = o_sample;
      got_sat = o_saturated;
      chk("busy_at_result", int'(o_busy), 0);
      @(negedge clk);
      chk("valid_one_cycle", int'(o_valid), 0);
   endtask
   task automatic stream(input int period, input int n_cyc, input bit rand_gain, input int exp_drops);
      logic signed [13:0] q_res[$];
      logic q_sat[$];
      logic signed [13:0] r, s;
      logic sat;
      int last_acc, drops_model, drops_seen, valids;
      last_acc = -100;
      drops_model = 0;
      drops_seen = 0;
      valids = 0;
      for (int c = 0; c < n_cyc + 20; c++) begin
         i_quotient_valid = rand_gain && (c < n_cyc) && ($urandom_range(0, 4) == 0);
         if (i_quotient_valid) begin
            i_quotient = 14'($urandom);
            model_gain = i_quotient;
         end
         s = 14'($urandom);
         if (c % 7 == 0) s = -14'sd8192;
         i_sample = s;
         i_start = (c < n_cyc) && (c % period == 0);
         if (i_start) begin
            if (c - last_acc >= 15) begin
               ref_scale(model_gain, s, r, sat);
               q_res.push_back(r);
               q_sat.push_back(sat);
               last_acc = c;
            end else drops_model++;
         end
         @(negedge clk);
         if (o_dropped) drops_seen++;
         if (o_valid) begin
            valids++;
            if (q_res.size() == 0) chk("stream_unexpected_valid", 1, 0);
            else begin
               chk("stream_sample", int'(o_sample), int'(q_res.pop_front()));
               chk("stream_sat", int'(o_saturated), int'(q_sat.pop_front()));
            end
         end
      end
      i_start = 1'b0;
      i_quotient_valid = 1'b0;
      chk("stream_pending_results", q_res.size(), 0);
      chk("stream_drops_vs_model", drops_seen, drops_model);
      if (exp_drops >= 0) chk("stream_drop_count", drops_seen, exp_drops);
      chk("stream_valid_nonzero", int'(valids > 0), 1);
   endtask
   initial begin
      logic signed [13:0] got;
      logic got_sat;
      int lat;
      bit bm, ds, seen;
      tbl[0] = '{0, 14'sd256, 14'sd1000, 14'sd1000, 0};
      tbl[1] = '{1, 14'sd512, -14'sd3000, -14'sd6000, 0};
      tbl[2] = '{1, 14'sd128, -14'sd3, -14'sd1, 0};
      tbl[3] = '{1, -14'sd256, 14'sd0, 14'sd0, 0};
      tbl[4] = '{1, 14'sd4096, 14'sd1000, 14'sd8191, 1};
      tbl[5] = '{1, 14'sd4096, -14'sd1000, -14'sd8192, 1};
      tbl[6] = '{1, -14'sd256, -14'sd8192, 14'sd8191, 1};
      tbl[7] = '{1, 14'sd256, -14'sd8192, -14'sd8192, 0};
      repeat (2) @(negedge clk);
      chk("rst_sample", int'(o_sample), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_sat", int'(o_saturated), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_dropped", int'(o_dropped), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].load) set_gain(tbl[i].g);
         do_op(tbl[i].s, -1, 0, 14'sd0, got, got_sat, lat, bm, ds);
         chk($sformatf("tbl%0d_sample", i), int'(got), int'(tbl[i].e));
         chk($sformatf("tbl%0d_sat", i), int'(got_sat), int'(tbl[i].sat));
         chk($sformatf("tbl%0d_latency", i), lat, 15);
         chk($sformatf("tbl%0d_busy_mid", i), int'(bm), 1);
      end
      i_quotient = 14'sd512;
      i_quotient_valid = 1'b1;
      model_gain = 14'sd512;
      do_op(14'sd100, -1, 0, 14'sd0, got, got_sat, lat, bm, ds);
      chk("bypass_gain", int'(got), 200);
      do_op(14'sd100, 6, 1, 14'sd768, got, got_sat, lat, bm, ds);
      model_gain = 14'sd768;
      chk("midmult_gain_ignored", int'(got), 200);
      do_op(14'sd100, -1, 0, 14'sd0, got, got_sat, lat, bm, ds);
      chk("next_uses_new_gain", int'(got), 300);
      do_op(14'sd700, 4, 2, 14'sd55, got, got_sat, lat, bm, ds);
      chk("drop_inflight_result", int'(got), 2100);
      chk("drop_pulse_seen", int'(ds), 1);
      chk("drop_latency", lat, 15);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid) seen = 1;
      end
      chk("dropped_no_result", int'(seen), 0);
      stream(15, 150, 1, 0);
      stream(4, 120, 0, -1);
      set_gain(14'sd512);
      i_sample = 14'sd1234;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_sample", int'(o_sample), 0);
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_valid", int'(o_valid), 0);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid) seen = 1;
      end
      chk("midrst_no_valid", int'(seen), 0);
      chk("midrst_sample_after", int'(o_sample), 0);
      model_gain = 14'sd256;
      do_op(14'sd50, -1, 0, 14'sd0, got, got_sat, lat, bm, ds);
      chk("post_rst_gain_unity", int'(got), 50);
      chk("post_rst_sat", int'(got_sat), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
